aes_key_expand: RTL and testbench

Iterative AES-128 key expansion engine. Accepts a 128-bit cipher key with a start pulse, computes one round key per clock, and holds the complete 11-round-key schedule, 1408 bits, for the encryption stage datapath. It sits directly upstream of `aes_encrypt_stage`, which consumes `key_schedule` with round key r at bits [r*128 +: 128].

---
 rtl/globals_aes.sv | 38 +++
 rtl/aes_key_round.sv | 34 +++
 rtl/aes_key_expand.sv | 81 ++++++++
 tb/tb_aes_key_expand.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/globals_aes.sv
// Shared AES constants, S-box table and key-expansion state type.
package globals_aes;

    localparam int BLOCK_SIZE        = 128;
    localparam int AES128_ROUNDS     = 10;
    localparam int KEY_SCHEDULE_SIZE = 1408;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } key_exp_state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-schedule step: RotWord, SubWord, rcon and the word XOR chain.
module aes_key_round
    import globals_aes::*;
(
    input  logic [0:127] prev_key,
    input  logic [0:7]   rcon,
    output logic [0:127] next_key
);

    logic [0:31] p0, p1, p2, p3;
    logic [0:31] rot, sub;
    logic [0:31] w0, w1, w2, w3;

    assign p0  = prev_key[0:31];
    assign p1  = prev_key[32:63];
    assign p2  = prev_key[64:95];
    assign p3  = prev_key[96:127];
    assign rot = {p3[8:31], p3[0:7]};

    always_comb begin
        sub = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sub[i*8 +: 8] = SBOX[rot[i*8 +: 8]];
        end
    end

    assign w0 = p0 ^ sub ^ {rcon, 24'h000000};
    assign w1 = p1 ^ w0;
    assign w2 = p2 ^ w1;
    assign w3 = p3 ^ w2;

    assign next_key = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-slot schedule register.
module aes_key_expand
    import globals_aes::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [0:127]    key,
    output logic            ready,
    output logic            schedule_valid,
    output logic [0:1407]   key_schedule
);

    localparam logic [3:0] LAST_ROUND = 4'(AES128_ROUNDS);

    key_exp_state_t state, state_next;
    logic [3:0]   round;
    logic [7:0]   rcon;
    logic [0:127] prev_key, next_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = EXPAND;
            EXPAND:     if (round == LAST_ROUND) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Source slot is round-1; decoded explicitly so no index ever leaves slots 0..9.
    always_comb begin
        prev_key = '0;
        for (int unsigned r = 0; r < AES128_ROUNDS; r++) begin
            if (round == 4'(r + 1)) prev_key = key_schedule[r*BLOCK_SIZE +: BLOCK_SIZE];
        end
    end

    aes_key_round u_round (
        .prev_key (prev_key),
        .rcon     (rcon),
        .next_key (next_key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_schedule <= '0;
            round        <= '0;
            rcon         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_schedule[0:127] <= key;
                        round               <= 4'd1;
                        rcon                <= 8'h01;
                    end
                end
                EXPAND: begin
                    for (int unsigned r = 1; r <= AES128_ROUNDS; r++) begin
                        if (round == 4'(r)) key_schedule[r*BLOCK_SIZE +: BLOCK_SIZE] <= next_key;
                    end
                    rcon <= xtime(rcon);
                    if (round != LAST_ROUND) round <= round + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign ready          = (state != EXPAND);
    assign schedule_valid = (state == DONE);

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed-vector bench for aes_key_expand using FIPS-197 and all-zero key schedules.
module tb_aes_key_expand;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [0:127]   key = '0;
    logic           ready;
    logic           schedule_valid;
    logic [0:1407]  key_schedule;

    int tests = 0;
    int fails = 0;
    int n;

    localparam logic [0:127] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] R1_A1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [0:127] R10_A1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [0:127] R1_Z    = 128'h62636363626363636263636362636363;
    localparam logic [0:127] R10_Z   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [0:127] PT      = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT      = 128'h3925841d02dc09fbdc118597196a0b32;

    always #5 clk = ~clk;

    aes_key_expand dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .key            (key),
        .ready          (ready),
        .schedule_valid (schedule_valid),
        .key_schedule   (key_schedule)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] slot(input int r);
        return key_schedule[r*128 +: 128];
    endfunction

    // Steps until schedule_valid rises; count capped so a stuck DUT still reaches the summary.
    task automatic run_to_valid(output int steps);
        steps = 0;
        while (!schedule_valid && steps < 30) begin
            step();
            steps++;
        end
    endtask

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] aes_encrypt(input logic [0:127] pt, input logic [0:1407] ks);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [0:127] out;
        for (int i = 0; i < 16; i++) s[i] = pt[i*8 +: 8] ^ ks[i*8 +: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = globals_aes::SBOX[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row + 4*col] = t[row + 4*((col + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    t[4*c]   = gm2(s[4*c]) ^ gm2(s[4*c+1]) ^ s[4*c+1] ^ s[4*c+2] ^ s[4*c+3];
                    t[4*c+1] = s[4*c] ^ gm2(s[4*c+1]) ^ gm2(s[4*c+2]) ^ s[4*c+2] ^ s[4*c+3];
                    t[4*c+2] = s[4*c] ^ s[4*c+1] ^ gm2(s[4*c+2]) ^ gm2(s[4*c+3]) ^ s[4*c+3];
                    t[4*c+3] = gm2(s[4*c]) ^ s[4*c] ^ s[4*c+1] ^ s[4*c+2] ^ gm2(s[4*c+3]);
                end
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[r*128 + i*8 +: 8];
        end
        for (int i = 0; i < 16; i++) out[i*8 +: 8] = s[i];
        return out;
    endfunction

    initial begin
        // Reset state
        #2;
        check("rst_ready", 128'(ready), 128'd1);
        check("rst_valid", 128'(schedule_valid), 128'd0);
        check("rst_sched_zero", 128'(|key_schedule), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_ready", 128'(ready), 128'd1);

        // FIPS-197 A.1
        key = KEY_A1; start = 1'b1;
        step();
        start = 1'b0; key = '1;
        check("a1_e0_ready", 128'(ready), 128'd0);
        check("a1_e0_valid", 128'(schedule_valid), 128'd0);
        check("a1_slot0", slot(0), KEY_A1);
        step();
        check("a1_slot1_after_e1", slot(1), R1_A1);
        run_to_valid(n);
        check("a1_valid_edges", 128'(n + 2), 128'd11);
        check("a1_slot10", slot(10), R10_A1);
        check("a1_done_ready", 128'(ready), 128'd1);
        check("a1_encrypt", aes_encrypt(PT, key_schedule), CT);
        repeat (5) step();
        check("a1_hold_valid", 128'(schedule_valid), 128'd1);
        check("a1_hold_slot10", slot(10), R10_A1);

        // Restart from DONE with the all-zero key
        key = '0; start = 1'b1;
        step();
        start = 1'b0;
        check("z_valid_drop", 128'(schedule_valid), 128'd0);
        n = 1;
        for (int i = 0; i < 30 && !schedule_valid; i++) begin
            step();
            if (!schedule_valid) n++;
        end
        check("z_valid_low_cycles", 128'(n), 128'd10);
        check("z_slot1", slot(1), R1_Z);
        check("z_slot10", slot(10), R10_Z);

        // start during EXPAND is ignored
        key = KEY_A1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        key = {128{1'b1}}; start = 1'b1;
        step();
        start = 1'b0;
        check("ign_ready_low", 128'(ready), 128'd0);
        run_to_valid(n);
        check("ign_valid_edges", 128'(n + 6), 128'd11);
        check("ign_slot0", slot(0), KEY_A1);
        check("ign_slot1", slot(1), R1_A1);
        check("ign_slot10", slot(10), R10_A1);

        // Asynchronous reset part-way through expansion
        key = '0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 128'(ready), 128'd1);
        check("mid_rst_valid", 128'(schedule_valid), 128'd0);
        check("mid_rst_sched_zero", 128'(|key_schedule), 128'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_idle_valid", 128'(schedule_valid), 128'd0);
        key = KEY_A1; start = 1'b1;
        step();
        start = 1'b0;
        run_to_valid(n);
        check("post_rst_valid_edges", 128'(n + 1), 128'd11);
        check("post_rst_slot1", slot(1), R1_A1);
        check("post_rst_slot10", slot(10), R10_A1);
        check("post_rst_encrypt", aes_encrypt(PT, key_schedule), CT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
